// File: rtl/rhs_unit_pkg.sv
// Shared types for the RHS unit: operation modes, FSM states and field widths.
package rhs_unit_pkg;
  localparam int OP_W   = 4;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LOGIC = 2'd0,
    SHL   = 2'd1,
    SHR   = 2'd2,
    ASR   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/rhs_unit_if.sv
// Request/response bundle between the operand latch, the RHS unit and the result bus.
interface rhs_unit_if #(
  parameter int WIDTH = 8
);
  logic                             in_valid;
  logic                             in_ready;
  logic [rhs_unit_pkg::MODE_W-1:0]  mode;
  logic [rhs_unit_pkg::OP_W-1:0]    operation;
  logic [WIDTH-1:0]                 lhs_in;
  logic [WIDTH-1:0]                 rhs_in;
  logic [WIDTH-1:0]                 out;
  logic                             out_valid;
  logic                             out_ready;
  logic                             zero;
  logic                             carry;

  modport master (
    output in_valid, mode, operation, lhs_in, rhs_in, out_ready,
    input  in_ready, out, out_valid, zero, carry
  );

  modport slave (
    input  in_valid, mode, operation, lhs_in, rhs_in, out_ready,
    output in_ready, out, out_valid, zero, carry
  );
endinterface

// File: rtl/rhs_logic.sv
// Combinational two-input bitwise function: each result bit indexes the 4-bit truth table.
module rhs_logic import rhs_unit_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = operation[{b[i], a[i]}];
    end
  end
endmodule

// File: rtl/rhs_unit.sv
// Handshaked RHS unit: bitwise LOGIC in one edge, serial shifts at one bit per clock.
// Define RHS_UNIT_ASR_EN to make mode 3 an arithmetic right shift (otherwise logical).
module rhs_unit import rhs_unit_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  rhs_unit_if.slave bus
);
  state_e             state, state_d;
  mode_e              mode_q, mode_d;
  logic [WIDTH-1:0]   work, work_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   logic_res;
  logic [WIDTH-1:0]   step_val;
  logic [SHIFT_W-1:0] cnt, cnt_d, n_in;
  logic               carry_q, carry_d, step_bit;

  assign n_in = bus.rhs_in[SHIFT_W-1:0];

  rhs_logic #(.WIDTH(WIDTH)) u_logic (
    .operation (bus.operation),
    .a         (bus.lhs_in),
    .b         (bus.rhs_in),
    .result    (logic_res)
  );

`ifdef RHS_UNIT_ASR_EN
  logic signed [WIDTH-1:0] work_s;
  assign work_s = work;
`endif

  // One serial step; the bit leaving the register becomes carry on the final step.
  always_comb begin
    step_val = {1'b0, work[WIDTH-1:1]};
    step_bit = work[0];
    if (mode_q == SHL) begin
      step_val = {work[WIDTH-2:0], 1'b0};
      step_bit = work[WIDTH-1];
    end
`ifdef RHS_UNIT_ASR_EN
    else if (mode_q == ASR) begin
      step_val = work_s >>> 1;
    end
`endif
  end

  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    work_d  = work;
    cnt_d   = cnt;
    out_d   = out_q;
    carry_d = carry_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mode_d = mode_e'(bus.mode);
          work_d = bus.lhs_in;
          cnt_d  = n_in;
          if (mode_e'(bus.mode) == LOGIC) begin
            out_d   = logic_res;
            carry_d = 1'b0;
            state_d = DONE;
          end else if (n_in == '0) begin
            out_d   = bus.lhs_in;
            carry_d = 1'b0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_val;
        cnt_d  = cnt - SHIFT_W'(1);
        if (cnt == SHIFT_W'(1)) begin
          out_d   = step_val;
          carry_d = step_bit;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // out/carry are architecturally visible after reset, so they sit with the control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state   <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    work   <= work_d;
    cnt    <= cnt_d;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = (out_q == '0);
endmodule

// File: tb/tb_rhs_unit.sv
// Directed bench for rhs_unit: vector table for LOGIC/shift results plus
// hand-written back-pressure and mid-shift reset sequences.
module tb_rhs_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rhs_unit_if #(.WIDTH(W)) bus ();
  rhs_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0] mode;
    logic [3:0] op;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic [7:0] exp_out;
    logic       exp_carry;
    int         exp_lat;
  } vec_t;

`ifdef RHS_UNIT_ASR_EN
  localparam logic [7:0] ASR_80_N2 = 8'hE0;
  localparam logic [7:0] ASR_C1_N1 = 8'hE0;
`else
  localparam logic [7:0] ASR_80_N2 = 8'h20;
  localparam logic [7:0] ASR_C1_N1 = 8'h60;
`endif

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int         lat;
    logic [7:0] o;
    logic       c, z;
    check($sformatf("v%0d in_ready before", idx), 32'(bus.in_ready), 32'd1);
    bus.mode      = v.mode;
    bus.operation = v.op;
    bus.lhs_in    = v.lhs;
    bus.rhs_in    = v.rhs;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; the captured operation must be unaffected.
    bus.in_valid  = 1'b0;
    bus.mode      = ~v.mode;
    bus.operation = ~v.op;
    bus.lhs_in    = ~v.lhs;
    bus.rhs_in    = ~v.rhs;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    o = bus.out;
    c = bus.carry;
    z = bus.zero;
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d out", idx), 32'(o), 32'(v.exp_out));
    check($sformatf("v%0d carry", idx), 32'(c), 32'(v.exp_carry));
    check($sformatf("v%0d zero", idx), 32'(z), 32'(v.exp_out == 8'h00));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check($sformatf("v%0d back to idle", idx), 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    for (int op = 0; op < 16; op++) begin
      vecs.push_back('{2'd0, 4'(op), 8'hAA, 8'hCC, {4'(op), 4'(op)}, 1'b0, 1});
    end
    vecs.push_back('{2'd2, 4'h0, 8'h81, 8'h01, 8'h40, 1'b1, 2});
    vecs.push_back('{2'd1, 4'h0, 8'h81, 8'hF3, 8'h08, 1'b0, 4});
    vecs.push_back('{2'd1, 4'h0, 8'h81, 8'h00, 8'h81, 1'b0, 1});
    vecs.push_back('{2'd2, 4'h0, 8'h81, 8'h07, 8'h01, 1'b0, 8});
    vecs.push_back('{2'd1, 4'h0, 8'h01, 8'h07, 8'h80, 1'b0, 8});
    vecs.push_back('{2'd2, 4'h0, 8'h02, 8'h02, 8'h00, 1'b1, 3});
    vecs.push_back('{2'd3, 4'h0, 8'h80, 8'h02, ASR_80_N2, 1'b0, 3});
    vecs.push_back('{2'd3, 4'h0, 8'hC1, 8'h01, ASR_C1_N1, 1'b1, 2});

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 2'd0;
    bus.operation = 4'h0;
    bus.lhs_in    = 8'h00;
    bus.rhs_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset out", 32'(bus.out), 32'h0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset carry", 32'(bus.carry), 32'd0);
    check("reset zero", 32'(bus.zero), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

    // Back-pressure: result must hold while new requests are offered.
    bus.mode      = 2'd0;
    bus.operation = 4'd6;
    bus.lhs_in    = 8'hAA;
    bus.rhs_in    = 8'hCC;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    check("bp first out_valid", 32'(bus.out_valid), 32'd1);
    check("bp first out", 32'(bus.out), 32'h66);
    bus.operation = 4'hF;
    bus.lhs_in    = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out", k), 32'(bus.out), 32'h66);
      check($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp release out", 32'(bus.out), 32'h66);

    // Leave carry=1 and a nonzero out so the mid-shift reset has something to clear.
    v = '{2'd1, 4'h0, 8'hFF, 8'h01, 8'hFE, 1'b1, 2};
    run_op(v, 100);

    bus.mode     = 2'd2;
    bus.lhs_in   = 8'hFF;
    bus.rhs_in   = 8'h07;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("mid in_ready in shift", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid reset out", 32'(bus.out), 32'h0);
    check("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    check("mid reset carry", 32'(bus.carry), 32'd0);
    check("mid reset zero", 32'(bus.zero), 32'd1);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid discarded out_valid", 32'(bus.out_valid), 32'd0);
    check("mid discarded out", 32'(bus.out), 32'h0);
    v = '{2'd0, 4'd8, 8'hAA, 8'hCC, 8'h88, 1'b0, 1};
    run_op(v, 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rhs_unit.md
# rhs_unit

Parametrised, handshaked successor to the combinational RHS logic stage of the ALU. It computes any of the 16 two-input bitwise functions of `lhs_in`/`rhs_in`, and also performs serial shifts that advance one bit per clock. Results are registered and held until consumed. The block sits between operand latch and result bus, and its flags feed the ALU flag logic.

## Interface
- `WIDTH`, 8: operand/result width in bits, ≥2
- `SHIFT_W`, `$clog2(WIDTH)`: width of the shift-amount field taken from `rhs_in`
- `clk` in 1: sole clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `in_valid` in 1: operation request
- `in_ready` out 1: block can accept a request
- `mode` in 2: 0 LOGIC, 1 SHL, 2 SHR, 3 ASR/SHR (see Configuration)
- `operation` in 4: truth table for LOGIC mode
- `lhs_in` in WIDTH: A operand, and the shift source
- `rhs_in` in WIDTH: B operand; bits [SHIFT_W-1:0] give the shift amount n
- `out` out WIDTH: registered result
- `out_valid` out 1: result available
- `out_ready` in 1: consumer takes the result
- `zero` out 1: `out == 0`, qualified by `out_valid`
- `carry` out 1: last bit shifted out; 0 for LOGIC and for n=0

## Operation
- Request accepted on an edge where `in_valid && in_ready`.
  - `mode`, `operation`, `lhs_in` and n are captured at acceptance.
  - Later input changes do not affect the operation in flight.
- LOGIC: `out[i] = operation[{rhs_in[i], lhs_in[i]}]` for every bit i.
  - 8 gives AND, 14 OR, 6 XOR, 0 zero, 15 all-ones.
- SHL: working register shifts left by 1 per cycle, n times, zero fill.
- SHR: shifts right by 1 per cycle, n times, zero fill.
- `carry` = bit shifted out on the final step.
- n ≥ WIDTH is legal. The serial shift simply runs n times (logical result 0). n=0 returns `lhs_in` with `carry`=0.
- FSM states IDLE, SHIFT, DONE:
  - IDLE → DONE when accepting LOGIC, or a shift with n=0.
  - IDLE → SHIFT when accepting a shift with n>0. Working register loads `lhs_in`; count loads n.
  - SHIFT: each edge performs one shift step and decrements count. Moves to DONE on the edge where count goes 1→0.
  - DONE → IDLE on an edge with `out_ready`.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- `out`, `zero` and `carry` are stable throughout DONE.
- `out` keeps its last value in IDLE and SHIFT. `out_valid` is the only qualifier.

## Timing
- Reset values: state IDLE, `out`=0, `carry`=0, `out_valid`=0, `in_ready`=1. `zero` is combinational from `out`, so it reads 1 after reset.
- Latency from the accept edge to `out_valid` high: 1 edge for LOGIC; 1+n edges for shifts.
- Throughput: at most one request in flight. The next request can be accepted one edge after the DONE→IDLE edge.
- Back-pressure: if `out_ready` stays low, DONE holds indefinitely. `in_valid` is ignored while `in_ready`=0.
- `out_ready` outside DONE has no effect.
- Reset asserted in any state, including mid-SHIFT, returns all outputs to their reset values on that edge. The in-flight operation is discarded.
- Reset takes priority over acceptance and over completion on the same edge.

## Configuration
- `RHS_UNIT_ASR_EN` defined: mode 3 is an arithmetic right shift that replicates `out[WIDTH-1]` each step. `carry` follows the same rule.
- Undefined: mode 3 behaves exactly as mode 2 (logical SHR). No ASR logic is synthesised.

## Structure
- `rhs_unit_pkg`: mode enum (LOGIC, SHL, SHR, ASR) and FSM state enum (IDLE, SHIFT, DONE).
- Sub-module `rhs_logic`: purely combinational, parametrised by WIDTH; maps `operation`, A and B to the LOGIC result.
- The FSM, shift register and counter live in `rhs_unit`.

## Test plan
- Reset: assert `reset` 2 cycles → `out`=0, `out_valid`=0, `in_ready`=1, `carry`=0.
- LOGIC sweep: `lhs_in`=8'b10101010, `rhs_in`=8'b11001100, `operation`=0..15 → `out` equals `{op,op}` in binary (e.g. op 6 → 8'b01100110). `out_valid` rises 1 edge after accept. `zero`=1 only for op 0.
- Shifts:
  - SHR `lhs_in`=8'h81, n=1 → `out`=8'h40, `carry`=1, latency 2.
  - SHL 8'h81, n=3 → 8'h08, `carry`=0, latency 4.
  - SHL n=0 → 8'h81, latency 1.
- Back-pressure: LOGIC result, `out_ready` low 3 cycles while `in_valid` stays high with new operands → `out` unchanged, `in_ready`=0, no second accept. `out_ready`=1 → IDLE next edge.
- Reset mid-shift: SHR 8'hFF, n=7, reset at the 3rd SHIFT edge → `out`=0, `out_valid`=0, `in_ready`=1 on that edge. A following LOGIC request completes normally.
- ASR: mode 3, `lhs_in`=8'h80, n=2 → 8'hE0 with `RHS_UNIT_ASR_EN`, 8'h20 without. `carry`=0 in both builds.
